// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - load/run/limit sequencer driving a loadable up-counter
module counter_sequencer #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_loop,
    input  logic [WIDTH-1:0] count,
    output logic             ld,
    output logic [WIDTH-1:0] v,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DIV_W-1:0]   presc;
    logic [WIDTH-1:0]   sh_start;
    logic [WIDTH-1:0]   sh_limit;
    logic [DIV_W-1:0]   sh_div;
    logic               sh_loop;
    logic               tick;
    logic               at_limit;

    // A tick is the last cycle of each prescaler period while running
    assign tick     = (state == RUN) && (presc == sh_div);
    assign at_limit = (count == sh_limit);
    assign v        = sh_start;
    assign busy     = (state == LOAD) || (state == RUN);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shadow config captured only when a start is accepted, so later cfg changes cannot disturb a run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_start <= '0;
            sh_limit <= '0;
            sh_div   <= '0;
            sh_loop  <= 1'b0;
        end else if (state == IDLE && start) begin
            sh_start <= cfg_start;
            sh_limit <= cfg_limit;
            sh_div   <= cfg_div;
            sh_loop  <= cfg_loop;
        end
    end

    // Prescaler cycles 0..div in RUN (including across loop reloads) and rests at 0 elsewhere
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (state == RUN && !abort) begin
            if (tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end else begin
            presc <= '0;
        end
    end

    // Next-state and strobe decode; abort suppresses every strobe and returns to IDLE
    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        en        = 1'b0;
        wrap      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    ld        = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (!at_limit) begin
                        en = 1'b1;
                    end else if (sh_loop) begin
                        ld   = 1'b1;
                        wrap = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                if (!abort) begin
                    done = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - scoreboard bench for counter_sequencer with a behavioural counter
module tb_counter_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  cfg_start = '0;
    logic [7:0]  cfg_limit = '0;
    logic [15:0] cfg_div = '0;
    logic        cfg_loop = 1'b0;
    logic [7:0]  count = '0;
    logic        ld;
    logic [7:0]  v;
    logic        en;
    logic        busy;
    logic        done;
    logic        wrap;

    int checks = 0;
    int passed = 0;

    // expected {ld, en, wrap, done, busy, v[7:0]} per cycle
    logic [12:0] exp_q[$];

    counter_sequencer #(.WIDTH(8), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_start(cfg_start), .cfg_limit(cfg_limit), .cfg_div(cfg_div), .cfg_loop(cfg_loop),
        .count(count), .ld(ld), .v(v), .en(en), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // loadable up-counter the sequencer controls
    always @(posedge clk) begin
        if (ld) count <= v;
        else if (en) count <= count + 8'd1;
    end

    // expectations from the timing formulas: ticks at 2+div+k(div+1), terminal tick k==N
    task automatic build_expect(input logic [7:0] s, input logic [7:0] l, input int d,
                                input bit lp, input int abort_at, input int last);
        logic [7:0] diff;
        int n;
        int term;
        diff = l - s;
        n = int'(diff);
        term = 1 + (n + 1) * (d + 1);
        for (int c = 1; c <= last; c++) begin
            logic e_ld, e_en, e_wr, e_dn, e_bs;
            int k;
            e_ld = (c == 1);
            e_en = 1'b0;
            e_wr = 1'b0;
            e_dn = !lp && (c == term + 1);
            e_bs = lp ? 1'b1 : (c <= term);
            if (c >= 2 + d && ((c - 2 - d) % (d + 1)) == 0) begin
                k = (c - 2 - d) / (d + 1);
                if (lp) begin
                    if ((k % (n + 1)) == n) begin
                        e_ld = 1'b1;
                        e_wr = 1'b1;
                    end else begin
                        e_en = 1'b1;
                    end
                end else if (k < n) begin
                    e_en = 1'b1;
                end
            end
            if (abort_at > 0 && c >= abort_at) begin
                e_ld = 1'b0; e_en = 1'b0; e_wr = 1'b0; e_dn = 1'b0;
                if (c > abort_at) e_bs = 1'b0;
            end
            exp_q.push_back({e_ld, e_en, e_wr, e_dn, e_bs, s});
        end
    endtask

    // drive cfg and a one-cycle start; returns at the negedge inside cycle 1
    task automatic launch(input logic [7:0] s, input logic [7:0] l, input logic [15:0] d, input logic lp);
        @(negedge clk);
        cfg_start = s; cfg_limit = l; cfg_div = d; cfg_loop = lp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // sample one cycle's outputs away from the clock edge, then move to the next cycle
    task automatic drive_cycle(input logic ab, output logic [12:0] obs, output logic [7:0] cnt_obs);
        abort = ab;
        #1;
        obs = {ld, en, wrap, done, busy, v};
        cnt_obs = count;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({ld, en, wrap, done, busy, v} !== 13'd0)
            $display("FAIL reset_state got %b exp %b", {ld, en, wrap, done, busy, v}, 13'd0);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic_stop(input string tag);
        logic [12:0] obs, e;
        logic [7:0] cnt;
        build_expect(8'd3, 8'd6, 0, 1'b0, 0, 8);
        launch(8'd3, 8'd6, 16'd0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            drive_cycle(1'b0, obs, cnt);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) $display("FAIL %s c%0d got %b exp %b", tag, c, obs, e);
            else passed++;
            if (c == 5) begin
                checks++;
                if (cnt !== 8'd6) $display("FAIL %s_count c5 got %0d exp 6", tag, cnt);
                else passed++;
            end
        end
    endtask

    task automatic test_prescaled();
        logic [12:0] obs, e;
        logic [7:0] cnt;
        build_expect(8'd0, 8'd2, 2, 1'b0, 0, 13);
        launch(8'd0, 8'd2, 16'd2, 1'b0);
        for (int c = 1; c <= 13; c++) begin
            drive_cycle(1'b0, obs, cnt);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) $display("FAIL prescaled c%0d got %b exp %b", c, obs, e);
            else passed++;
        end
    endtask

    task automatic test_loop_abort();
        logic [12:0] obs, e;
        logic [7:0] cnt;
        build_expect(8'd5, 8'd6, 0, 1'b1, 8, 10);
        launch(8'd5, 8'd6, 16'd0, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            drive_cycle(c == 8, obs, cnt);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) $display("FAIL loop_abort c%0d got %b exp %b", c, obs, e);
            else passed++;
            if (c == 4) begin
                checks++;
                if (cnt !== 8'd5) $display("FAIL loop_reload_count c4 got %0d exp 5", cnt);
                else passed++;
            end
        end
    endtask

    task automatic test_wrap_around();
        logic [12:0] obs, e;
        logic [7:0] cnt;
        build_expect(8'd254, 8'd1, 0, 1'b0, 0, 8);
        launch(8'd254, 8'd1, 16'd0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            drive_cycle(1'b0, obs, cnt);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) $display("FAIL wrap_around c%0d got %b exp %b", c, obs, e);
            else passed++;
        end
    endtask

    task automatic test_degenerate();
        logic [12:0] obs, e;
        logic [7:0] cnt;
        build_expect(8'd9, 8'd9, 0, 1'b0, 0, 5);
        launch(8'd9, 8'd9, 16'd0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            drive_cycle(1'b0, obs, cnt);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) $display("FAIL degenerate c%0d got %b exp %b", c, obs, e);
            else passed++;
        end
    endtask

    task automatic test_cfg_change_ignored();
        logic [12:0] obs, e;
        logic [7:0] cnt;
        build_expect(8'd10, 8'd14, 1, 1'b0, 0, 14);
        launch(8'd10, 8'd14, 16'd1, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) begin
                start = 1'b1; cfg_start = 8'd50; cfg_limit = 8'd51; cfg_div = 16'd0; cfg_loop = 1'b1;
            end
            if (c == 4) start = 1'b0;
            drive_cycle(1'b0, obs, cnt);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) $display("FAIL cfg_ignored c%0d got %b exp %b", c, obs, e);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        logic [12:0] obs, e;
        logic [7:0] cnt;
        build_expect(8'd0, 8'd200, 0, 1'b0, 0, 3);
        launch(8'd0, 8'd200, 16'd0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            drive_cycle(1'b0, obs, cnt);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) $display("FAIL async_pre c%0d got %b exp %b", c, obs, e);
            else passed++;
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({ld, en, wrap, done, busy, v} !== 13'd0)
            $display("FAIL async_reset_now got %b exp %b", {ld, en, wrap, done, busy, v}, 13'd0);
        else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if ({ld, en, wrap, done, busy, v} !== 13'd0)
            $display("FAIL async_reset_held got %b exp %b", {ld, en, wrap, done, busy, v}, 13'd0);
        else passed++;
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_stop("basic_stop");
        test_prescaled();
        test_loop_abort();
        test_wrap_around();
        test_degenerate();
        test_cfg_change_ignored();
        test_async_reset();
        test_basic_stop("after_reset");
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
